lsu_load: RTL and testbench
===========================

# lsu_load

Load-side memory reader for the RV64 core; the read counterpart of the register-file store path that issues memory writes. The block accepts one decoded load at a time: effective address `base + sext(imm)`, funct3 and destination register. It issues an 8-byte-aligned read request to data memory, waits for the response and extracts the addressed byte/half/word/double with sign or zero extension. It then drives a one-cycle write-back into the register file. It sits between execute and the register file's write port.

## Interface
- CPU_WIDTH, 64, datapath / address width
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ld_valid  in  1  load command valid
- ld_ready  out  1  block can accept a command (high only in IDLE)
- ld_base  in  64  base register value
- ld_imm  in  32  signed offset
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal
- ld_rd  in  5  destination register
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_raddr  out  64  aligned read address, bits [2:0] always 0
- mem_rvalid  in  1  read data valid (one-cycle pulse)
- mem_rdata  in  64  read data, little-endian doubleword
- wb_wen  out  1  register write enable
- wb_waddr  out  5  register write address
- wb_wdata  out  64  register write data
- ld_err  out  1  one-cycle pulse: misaligned address or illegal funct3
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, REQ, WAIT, WB, ERR.
- IDLE: ld_ready=1. On ld_valid: latch eff=ld_base+{{32{ld_imm[31]}},ld_imm} (mod 2^64), funct3 and rd.
  - Next state is ERR if funct3=111, LH/LHU with eff[0]!=0, LW/LWU with eff[1:0]!=0, or LD with eff[2:0]!=0.
  - Otherwise next state is REQ.
- REQ: mem_req_valid=1, mem_raddr={eff[63:3],3'b000}, held stable until mem_req_ready=1. Then go to WAIT.
- WAIT: sample mem_rvalid. On 1, latch the extracted data and go to WB. mem_rvalid is ignored in IDLE, REQ, WB and ERR.
- Extraction:
  - sh = mem_rdata >> (eff[2:0]*8).
  - LB/LBU use sh[7:0], LH/LHU use sh[15:0], LW/LWU use sh[31:0], LD uses sh.
  - Signed loads sign-extend to 64 bits; U loads zero-extend.
- WB: wb_wen=1 for exactly one cycle with wb_waddr=rd and wb_wdata=result. If rd=0, wb_wen=0 but the WB cycle still occurs. Then go to IDLE.
- ERR: ld_err=1 for one cycle, no memory request, no write-back. Then go to IDLE.
- Only one load is outstanding at a time. No request pipelining.

## Timing
- Reset values: state IDLE, ld_ready=1, mem_req_valid=0, mem_raddr=0, wb_wen=0, wb_waddr=0, wb_wdata=0, ld_err=0, busy=0.
- All outputs are registered or decoded from the state register. There is no combinational path from ld_valid or mem_rvalid to any output.
- Minimum latency:
  - Accept edge E0, REQ during cycle 1, handshake at E1, WAIT during cycle 2, rvalid sampled at E2.
  - wb_wen is high in the cycle following E2. The register file writes at E3.
  - ld_ready returns high after E3.
- Each cycle mem_req_ready stays low adds one cycle. Each cycle mem_rvalid is delayed adds one cycle.
- Error path: accept at E0, ld_err high during cycle 1, ld_ready high again after E1.
- Address wrap: eff computed modulo 2^64 (e.g. base=0, imm=-8 gives 0xFFFF_FFFF_FFFF_FFF8).
- Reset mid-operation: return immediately to IDLE with reset values. Any response arriving after reset release while in IDLE is dropped.
- mem_rvalid asserted in the same cycle as the request handshake is ignored. Memory must respond no earlier than the following cycle.

## Test plan
- LB, base=0x8000_0000, imm=5, mem_rdata=0x0000_F000_0000_0000 -> mem_raddr=0x8000_0000, wb_wdata=0xFFFF_FFFF_FFFF_FFF0, wb_wen one cycle, at E3 with zero-wait memory.
- LHU, base=0x8000_0010, imm=-2, rdata=0x8001_0000_0000_0000 -> mem_raddr=0x8000_0008, wb_wdata=0x0000_0000_0000_8001. Repeat with LH -> 0xFFFF_FFFF_FFFF_8001.
- LW with eff[1:0]=2'b10 -> ld_err pulse one cycle, mem_req_valid never asserted, wb_wen stays 0. Same check for funct3=111.
- LD to rd=0 with mem_req_ready low for 3 cycles and rvalid 2 cycles late:
  - mem_raddr held stable while mem_req_valid waits.
  - wb_wen stays 0 throughout.
  - Total latency is 8 cycles.
- Reset asserted during WAIT, then a mem_rvalid pulse after release -> all outputs return to reset values, no write-back, ld_ready=1.
- Back-to-back LWU commands with ld_valid held high -> the second command is accepted only on the edge after WB. wb_wdata upper 32 bits are 0 when data bit 31 is 1.

Source files
------------

// File: rtl/lsu_load.sv
// rtl/lsu_load.sv - single-outstanding load unit: aligned read, byte-lane extract, register write-back
module lsu_load #(
  parameter int CPU_WIDTH      = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [CPU_WIDTH-1:0]      ld_base,
  input  logic [31:0]               ld_imm,
  input  logic [2:0]                ld_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [CPU_WIDTH-1:0]      mem_raddr,
  input  logic                      mem_rvalid,
  input  logic [CPU_WIDTH-1:0]      mem_rdata,
  output logic                      wb_wen,
  output logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic [CPU_WIDTH-1:0]      wb_wdata,
  output logic                      ld_err,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_ERR
  } state_t;

  state_t                      state;
  logic [CPU_WIDTH-1:0]        eff;
  logic [2:0]                  funct3;
  logic [REG_ADDR_WIDTH-1:0]   rd;
  logic [CPU_WIDTH-1:0]        result;

  logic [CPU_WIDTH-1:0]        eff_next;
  logic                        misaligned;
  logic                        illegal;
  logic [CPU_WIDTH-1:0]        sh;
  logic [CPU_WIDTH-1:0]        ext;

  always_comb begin
    eff_next = ld_base + {{(CPU_WIDTH-32){ld_imm[31]}}, ld_imm};
    illegal  = (ld_funct3 == 3'b111);
    // Access size comes from funct3[1:0]; bytes are never misaligned.
    misaligned = 1'b0;
    case (ld_funct3[1:0])
      2'b01:   misaligned = eff_next[0];
      2'b10:   misaligned = |eff_next[1:0];
      2'b11:   misaligned = |eff_next[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    sh  = mem_rdata >> {eff[2:0], 3'b000};
    ext = sh;
    case (funct3)
      3'b000:  ext = {{(CPU_WIDTH-8){sh[7]}},   sh[7:0]};
      3'b001:  ext = {{(CPU_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b010:  ext = {{(CPU_WIDTH-32){sh[31]}}, sh[31:0]};
      3'b100:  ext = {{(CPU_WIDTH-8){1'b0}},    sh[7:0]};
      3'b101:  ext = {{(CPU_WIDTH-16){1'b0}},   sh[15:0]};
      3'b110:  ext = {{(CPU_WIDTH-32){1'b0}},   sh[31:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      eff    <= '0;
      funct3 <= '0;
      rd     <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_valid) begin
            eff    <= eff_next;
            funct3 <= ld_funct3;
            rd     <= ld_rd;
            state  <= (illegal || misaligned) ? S_ERR : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          // Responses are only honoured here, so a pulse coincident with the handshake is dropped.
          if (mem_rvalid) begin
            result <= ext;
            state  <= S_WB;
          end
        end
        S_WB:    state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ld_ready      = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign mem_req_valid = (state == S_REQ);
  assign mem_raddr     = {eff[CPU_WIDTH-1:3], 3'b000};
  assign wb_wen        = (state == S_WB) && (rd != '0);
  assign wb_waddr      = rd;
  assign wb_wdata      = result;
  assign ld_err        = (state == S_ERR);

endmodule

// File: tb/tb_lsu_load.sv
// tb/tb_lsu_load.sv - randomized and directed self-checking bench for lsu_load
module tb_lsu_load;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_base;
  logic [31:0] ld_imm;
  logic [2:0]  ld_funct3;
  logic [4:0]  ld_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_raddr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        ld_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_load #(.CPU_WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_base      (ld_base),
    .ld_imm       (ld_imm),
    .ld_funct3    (ld_funct3),
    .ld_rd        (ld_rd),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_raddr    (mem_raddr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wb_wen       (wb_wen),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .ld_err       (ld_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: access width and signedness straight from the funct3 table.
  function automatic void model(input logic [2:0] f3, input logic [63:0] eff,
                                input logic [63:0] rdata, output bit err,
                                output logic [63:0] res);
    int nbytes;
    bit sgn;
    logic [63:0] mask;
    logic [63:0] val;
    nbytes = 8;
    sgn    = 1'b0;
    case (f3)
      3'd0: begin nbytes = 1; sgn = 1'b1; end
      3'd1: begin nbytes = 2; sgn = 1'b1; end
      3'd2: begin nbytes = 4; sgn = 1'b1; end
      3'd3: begin nbytes = 8; sgn = 1'b1; end
      3'd4: begin nbytes = 1; sgn = 1'b0; end
      3'd5: begin nbytes = 2; sgn = 1'b0; end
      3'd6: begin nbytes = 4; sgn = 1'b0; end
      default: nbytes = 8;
    endcase
    err = (f3 == 3'd7) || ((eff % 64'(nbytes)) != 64'd0);
    val = rdata >> (8 * (eff % 64'd8));
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      val  = val & mask;
      if (sgn && val[8*nbytes-1]) val = val | ~mask;
    end
    res = val;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [63:0] base,
                       input logic [31:0] imm, input logic [4:0] rd);
    check("accept_ready", 64'(ld_ready), 64'd1);
    ld_valid  = 1'b1;
    ld_funct3 = f3;
    ld_base   = base;
    ld_imm    = imm;
    ld_rd     = rd;
    @(negedge clk);
  endtask

  // Entered at the negedge of the first cycle after the accept edge.
  task automatic complete(input logic [2:0] f3, input logic [63:0] base,
                          input logic [31:0] imm, input logic [4:0] rd,
                          input int req_wait, input int rsp_wait,
                          input logic [63:0] rdata, output logic [63:0] wd);
    logic [63:0] eff;
    logic [63:0] exp;
    bit          err;
    eff = base + {{32{imm[31]}}, imm};
    model(f3, eff, rdata, err, exp);
    wd = '0;
    if (err) begin
      check("err_pulse", 64'(ld_err), 64'd1);
      check("err_noreq", 64'(mem_req_valid), 64'd0);
      check("err_nowb", 64'(wb_wen), 64'd0);
      check("err_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("err_clear", 64'(ld_err), 64'd0);
      check("err_ready", 64'(ld_ready), 64'd1);
      check("err_nowb2", 64'(wb_wen), 64'd0);
      return;
    end
    for (int k = 0; k <= req_wait; k++) begin
      check("req_valid", 64'(mem_req_valid), 64'd1);
      check("req_addr", mem_raddr, {eff[63:3], 3'b000});
      check("req_notready", 64'(ld_ready), 64'd0);
      mem_req_ready = (k == req_wait);
      mem_rvalid    = (k == req_wait);
      mem_rdata     = ~rdata;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    for (int k = 0; k <= rsp_wait; k++) begin
      check("wait_noreq", 64'(mem_req_valid), 64'd0);
      check("wait_nowb", 64'(wb_wen), 64'd0);
      mem_rvalid = (k == rsp_wait);
      mem_rdata  = (k == rsp_wait) ? rdata : {$urandom, $urandom};
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    check("wb_wen", 64'(wb_wen), 64'(rd != 5'd0));
    check("wb_addr", 64'(wb_waddr), 64'(rd));
    check("wb_data", wb_wdata, exp);
    check("wb_notready", 64'(ld_ready), 64'd0);
    wd = wb_wdata;
    @(negedge clk);
    check("wb_single", 64'(wb_wen), 64'd0);
    check("ret_ready", 64'(ld_ready), 64'd1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [63:0] base,
                         input logic [31:0] imm, input logic [4:0] rd,
                         input int req_wait, input int rsp_wait,
                         input logic [63:0] rdata, output logic [63:0] wd);
    issue(f3, base, imm, rd);
    ld_valid = 1'b0;
    complete(f3, base, imm, rd, req_wait, rsp_wait, rdata, wd);
  endtask

  initial begin
    logic [63:0] wd;
    logic [63:0] base;
    logic [31:0] imm;
    logic [63:0] rdata;
    rst_n         = 1'b0;
    ld_valid      = 1'b0;
    ld_base       = '0;
    ld_imm        = '0;
    ld_funct3     = '0;
    ld_rd         = '0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ld_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'(mem_req_valid), 64'd0);
    check("rst_raddr", mem_raddr, 64'd0);
    check("rst_wen", 64'(wb_wen), 64'd0);
    check("rst_waddr", 64'(wb_waddr), 64'd0);
    check("rst_wdata", wb_wdata, 64'd0);
    check("rst_err", 64'(ld_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(3'b000, 64'h8000_0000, 32'd5, 5'd3, 0, 0, 64'h0000_F000_0000_0000, wd);
    check("lb_value", wd, 64'hFFFF_FFFF_FFFF_FFF0);
    do_load(3'b101, 64'h8000_0010, 32'hFFFF_FFFE, 5'd4, 0, 0, 64'h8001_0000_0000_0000, wd);
    check("lhu_value", wd, 64'h0000_0000_0000_8001);
    do_load(3'b001, 64'h8000_0010, 32'hFFFF_FFFE, 5'd4, 1, 0, 64'h8001_0000_0000_0000, wd);
    check("lh_value", wd, 64'hFFFF_FFFF_FFFF_8001);
    do_load(3'b010, 64'h1000, 32'd2, 5'd5, 0, 0, 64'h0, wd);
    do_load(3'b111, 64'h1000, 32'd0, 5'd5, 0, 0, 64'h0, wd);
    do_load(3'b011, 64'h1000, 32'd4, 5'd6, 0, 0, 64'h0, wd);
    do_load(3'b011, 64'h2000, 32'd8, 5'd0, 3, 2, 64'h0123_4567_89AB_CDEF, wd);
    do_load(3'b011, 64'h0, 32'hFFFF_FFF8, 5'd9, 0, 1, 64'hDEAD_BEEF_0000_0001, wd);
    check("wrap_value", wd, 64'hDEAD_BEEF_0000_0001);

    // Back-to-back LWU with ld_valid held high across the first load.
    issue(3'b110, 64'h3000, 32'd4, 5'd10);
    ld_base = 64'h3000;
    ld_imm  = 32'd0;
    ld_rd   = 5'd11;
    complete(3'b110, 64'h3000, 32'd4, 5'd10, 0, 0, 64'h8765_4321_0000_0000, wd);
    check("b2b_first_hi", wd, 64'h0000_0000_8765_4321);
    @(negedge clk);
    ld_valid = 1'b0;
    complete(3'b110, 64'h3000, 32'd0, 5'd11, 0, 0, 64'h0000_0000_9000_0001, wd);
    check("b2b_second_hi", 64'(wd[63:32]), 64'd0);

    // Reset while waiting for the response, then a stray response after release.
    issue(3'b011, 64'h4000, 32'd0, 5'd7);
    ld_valid      = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n         = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(ld_ready), 64'd1);
    check("mid_rst_req", 64'(mem_req_valid), 64'd0);
    check("mid_rst_raddr", mem_raddr, 64'd0);
    check("mid_rst_wdata", wb_wdata, 64'd0);
    check("mid_rst_waddr", 64'(wb_waddr), 64'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("post_rst_wen", 64'(wb_wen), 64'd0);
      check("post_rst_ready", 64'(ld_ready), 64'd1);
      check("post_rst_wdata", wb_wdata, 64'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 60; i++) begin
      base = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) base[2:0] = 3'b000;
      imm   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
      rdata = {$urandom, $urandom};
      do_load(3'($urandom_range(0, 7)), base, imm, 5'($urandom_range(0, 31)),
              $urandom_range(0, 3), $urandom_range(0, 3), rdata, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
